// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the ccff chain loader and its readback packer.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold the values 0..chain_len inclusive.
  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Width of a bit index into a word of word_w bits (at least one bit).
  function automatic int idx_w(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Valid/ready bitstream word stream feeding the ccff chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 4
);

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  // Bitstream source side.
  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  // Loader side.
  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/ccff_rb_packer.sv
// Collects bits leaving the chain tail into readback words, LSB first.
// A word is emitted when it fills up or when the last bit of the session
// arrives; a partial final word is zero-padded.
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 4
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              clear,
  input  logic              sample,
  input  logic              bit_in,
  input  logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int IW = idx_w(WORD_W);
  localparam logic [IW-1:0] LAST_POS = IW'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic [IW-1:0]     pos_q, pos_d;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] merged;

  // Packer state register with synchronous reset.
  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      acc_q      <= '0;
      rb_data_q  <= '0;
      pos_q      <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      rb_data_q  <= rb_data_d;
      pos_q      <= pos_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Insert the sampled bit and decide whether a finished word goes out.
  always_comb begin
    acc_d      = acc_q;
    rb_data_d  = rb_data_q;
    pos_d      = pos_q;
    rb_valid_d = 1'b0;
    merged     = acc_q;
    if (clear) begin
      acc_d = '0;
      pos_d = '0;
    end else if (sample) begin
      merged[pos_q] = bit_in;
      if ((pos_q == LAST_POS) || last) begin
        rb_data_d  = merged;
        rb_valid_d = 1'b1;
        acc_d      = '0;
        pos_d      = '0;
      end else begin
        acc_d = merged;
        pos_d = pos_q + 1'b1;
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words onto the head of a ccff configuration chain.
// Optional readback of the bits leaving the chain tail: define CCFF_READBACK_EN.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 4
) (
  input  logic                prog_clock,
  input  logic                prog_reset,
  input  logic                start,
  ccff_chain_loader_if.slave  s_if,
  output logic                ccff_head,
  output logic                config_enable,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic [WORD_W-1:0]   rb_data,
  output logic                rb_valid
);

  localparam int CW = cnt_w(CHAIN_LEN);
  localparam int IW = idx_w(WORD_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LEN);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              head_q, head_d;
  logic              enable_q, enable_d;

  // State, counters and the registered chain-facing outputs.
  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      head_q    <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      bit_cnt_q <= bit_cnt_d;
      head_q    <= head_d;
      enable_q  <= enable_d;
    end
  end

  // Next-state logic; the first bit of a word is presented in the same edge
  // that accepts it, and the remaining bits follow one per cycle.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    head_d    = 1'b0;
    enable_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          idx_d     = '0;
          bit_cnt_d = '0;
        end
      end
      FETCH: begin
        if (s_if.s_valid) begin
          word_d    = s_if.s_data;
          head_d    = s_if.s_data[0];
          enable_d  = 1'b1;
          idx_d     = IW'(1);
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else if (idx_q == '0) begin
          state_d = FETCH;
        end else begin
          head_d    = word_q[idx_q];
          enable_d  = 1'b1;
          idx_d     = idx_q + 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_if.s_ready  = (state_q == FETCH);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign ccff_head     = head_q;
  assign config_enable = enable_q;

`ifdef CCFF_READBACK_EN
  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .prog_clock (prog_clock),
    .prog_reset (prog_reset),
    .clear      ((state_q == IDLE) && start),
    .sample     (enable_q),
    .bit_in     (ccff_tail),
    .last       (bit_cnt_q == LAST_CNT),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed testbench for ccff_chain_loader with a behavioural 10-flop chain model.
// Readback checks are compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 10;
  localparam int WORD_W    = 4;

  logic              prog_clock = 1'b0;
  logic              prog_reset = 1'b1;
  logic              start      = 1'b0;
  logic              ccff_head;
  logic              config_enable;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) s_if ();

  ccff_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) dut (
    .prog_clock    (prog_clock),
    .prog_reset    (prog_reset),
    .start         (start),
    .s_if          (s_if),
    .ccff_head     (ccff_head),
    .config_enable (config_enable),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid)
  );

  // Free-running programming clock.
  always #5 prog_clock = ~prog_clock;

  // Chain model: head enters bit 0, tail is bit CHAIN_LEN-1.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 preload_req = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;

  always @(posedge prog_clock) begin
    if (preload_req) chain <= preload_val;
    else if (config_enable) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  assign ccff_tail = chain[CHAIN_LEN-1];

  // Observation state gathered on the falling edge.
  int   cyc = 0;
  bit   heads[$];
  int   en_cyc[$];
  logic [WORD_W-1:0] rb_words[$];
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   overlap_cnt = 0;
  int   rb_total = 0;

  int   checks = 0;
  int   fails  = 0;

  // Monitor samples DUT outputs mid-cycle, away from the active edge.
  always @(negedge prog_clock) begin
    cyc++;
    if (config_enable) begin
      heads.push_back(ccff_head);
      en_cyc.push_back(cyc);
    end
    if (s_if.s_valid && s_if.s_ready) hs_cnt++;
    if (done) done_cnt++;
    if (config_enable && s_if.s_ready) overlap_cnt++;
    if (rb_valid) begin
      rb_words.push_back(rb_data);
      rb_total++;
    end
  end

  task automatic clear_mon;
    heads.delete();
    en_cyc.delete();
    rb_words.delete();
    hs_cnt      = 0;
    done_cnt    = 0;
    overlap_cnt = 0;
  endtask

  // Drives one load session of three words; optional stall before word 1.
  task automatic run_session(input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input int stall,
                             output bit timed_out);
    logic [3:0] w[3];
    bit got;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    timed_out = 1'b0;
    @(posedge prog_clock); #1 start = 1'b1;
    @(posedge prog_clock); #1 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      if (k == 1 && stall > 0) begin
        s_if.s_valid = 1'b0;
        repeat (stall) @(posedge prog_clock);
        #1;
      end
      s_if.s_data  = w[k];
      s_if.s_valid = 1'b1;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge prog_clock);
        if (s_if.s_ready) begin
          @(posedge prog_clock); #1;
          got = 1'b1;
        end
      end
      s_if.s_valid = 1'b0;
      if (!got) timed_out = 1'b1;
    end
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(posedge prog_clock); #1;
      if (done) got = 1'b1;
    end
    if (!got) timed_out = 1'b1;
    repeat (3) @(posedge prog_clock);
    #1;
  endtask

  task automatic test_reset;
    prog_reset  = 1'b1;
    preload_val = '0;
    preload_req = 1'b1;
    repeat (3) @(posedge prog_clock);
    #1 preload_req = 1'b0;
    checks++; if (config_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_config_enable: got %b expected 0", config_enable); end
    checks++; if (ccff_head !== 1'b0) begin fails++; $display("[TB] FAIL reset_ccff_head: got %b expected 0", ccff_head); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (s_if.s_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_if.s_ready); end
    checks++; if (rb_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rb_valid: got %b expected 0", rb_valid); end
    checks++; if (rb_data !== 4'h0) begin fails++; $display("[TB] FAIL reset_rb_data: got %h expected 0", rb_data); end
    prog_reset = 1'b0;
    repeat (2) @(posedge prog_clock);
    #1;
  endtask

  task automatic test_basic_load;
    logic [9:0] exp_seq;
    bit to;
    exp_seq = 10'b1110100101;
    clear_mon();
    run_session(4'h5, 4'hA, 4'h3, 0, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL basic_timeout: got timeout expected completion"); end
    checks++; if (heads.size() != 10) begin fails++; $display("[TB] FAIL basic_enable_cycles: got %0d expected 10", heads.size()); end
    for (int i = 0; i < 10 && i < heads.size(); i++) begin
      checks++; if (heads[i] !== exp_seq[i]) begin fails++; $display("[TB] FAIL basic_bit%0d: got %b expected %b", i, heads[i], exp_seq[i]); end
    end
    checks++; if (hs_cnt != 3) begin fails++; $display("[TB] FAIL basic_handshakes: got %0d expected 3", hs_cnt); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
    checks++; if (overlap_cnt != 0) begin fails++; $display("[TB] FAIL basic_enable_in_fetch: got %0d expected 0", overlap_cnt); end
    checks++; if (chain !== 10'b1010010111) begin fails++; $display("[TB] FAIL basic_chain: got %b expected 1010010111", chain); end
    if (en_cyc.size() >= 5) begin
      checks++; if (en_cyc[4] - en_cyc[3] != 2) begin fails++; $display("[TB] FAIL basic_word_gap: got %0d expected 2", en_cyc[4] - en_cyc[3]); end
    end
  endtask

  task automatic test_stall;
    logic [9:0] exp_seq;
    bit to;
    exp_seq = 10'b1110100101;
    clear_mon();
    run_session(4'h5, 4'hA, 4'h3, 5, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL stall_timeout: got timeout expected completion"); end
    checks++; if (heads.size() != 10) begin fails++; $display("[TB] FAIL stall_enable_cycles: got %0d expected 10", heads.size()); end
    for (int i = 0; i < 10 && i < heads.size(); i++) begin
      checks++; if (heads[i] !== exp_seq[i]) begin fails++; $display("[TB] FAIL stall_bit%0d: got %b expected %b", i, heads[i], exp_seq[i]); end
    end
    if (en_cyc.size() >= 5) begin
      checks++; if (en_cyc[4] - en_cyc[3] != 3) begin fails++; $display("[TB] FAIL stall_word_gap: got %0d expected 3", en_cyc[4] - en_cyc[3]); end
    end
    checks++; if (overlap_cnt != 0) begin fails++; $display("[TB] FAIL stall_enable_in_fetch: got %0d expected 0", overlap_cnt); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL stall_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_start_while_busy;
    bit to;
    clear_mon();
    fork
      run_session(4'h5, 4'hA, 4'h3, 0, to);
      begin
        for (int t = 0; t < 100 && heads.size() < 4; t++) begin
          @(negedge prog_clock); #1;
        end
        @(posedge prog_clock); #1 start = 1'b1;
        @(posedge prog_clock); #1 start = 1'b0;
      end
    join
    repeat (4) @(posedge prog_clock);
    #1;
    checks++; if (to) begin fails++; $display("[TB] FAIL busy_start_timeout: got timeout expected completion"); end
    checks++; if (heads.size() != 10) begin fails++; $display("[TB] FAIL busy_start_shifts: got %0d expected 10", heads.size()); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL busy_start_done: got %0d expected 1", done_cnt); end
    checks++; if (hs_cnt != 3) begin fails++; $display("[TB] FAIL busy_start_handshakes: got %0d expected 3", hs_cnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL busy_start_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_shift;
    logic [9:0] exp_seq;
    bit to;
    exp_seq = 10'b0101101100;
    clear_mon();
    @(posedge prog_clock); #1 start = 1'b1;
    @(posedge prog_clock); #1 start = 1'b0;
    s_if.s_data  = 4'h5;
    s_if.s_valid = 1'b1;
    for (int t = 0; t < 40 && heads.size() < 1; t++) begin
      @(negedge prog_clock); #1;
    end
    s_if.s_data = 4'hA;
    for (int t = 0; t < 40 && heads.size() < 6; t++) begin
      @(negedge prog_clock); #1;
    end
    checks++; if (heads.size() != 6) begin fails++; $display("[TB] FAIL rst_mid_reach_bit6: got %0d expected 6", heads.size()); end
    prog_reset = 1'b1;
    @(posedge prog_clock); #1;
    checks++; if (config_enable !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_config_enable: got %b expected 0", config_enable); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (s_if.s_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_s_ready: got %b expected 0", s_if.s_ready); end
    s_if.s_valid = 1'b0;
    prog_reset   = 1'b0;
    @(posedge prog_clock); #1;
    clear_mon();
    run_session(4'hC, 4'h6, 4'h1, 0, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL rst_fresh_timeout: got timeout expected completion"); end
    checks++; if (heads.size() != 10) begin fails++; $display("[TB] FAIL rst_fresh_shifts: got %0d expected 10", heads.size()); end
    for (int i = 0; i < 10 && i < heads.size(); i++) begin
      checks++; if (heads[i] !== exp_seq[i]) begin fails++; $display("[TB] FAIL rst_fresh_bit%0d: got %b expected %b", i, heads[i], exp_seq[i]); end
    end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL rst_fresh_done: got %0d expected 1", done_cnt); end
    checks++; if (chain !== 10'b0011011010) begin fails++; $display("[TB] FAIL rst_fresh_chain: got %b expected 0011011010", chain); end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback;
    bit to;
    preload_val = '1;
    preload_req = 1'b1;
    @(posedge prog_clock); #1 preload_req = 1'b0;
    clear_mon();
    run_session(4'h0, 4'h0, 4'h0, 0, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL rb_timeout: got timeout expected completion"); end
    checks++; if (rb_words.size() != 3) begin fails++; $display("[TB] FAIL rb_pulses: got %0d expected 3", rb_words.size()); end
    if (rb_words.size() >= 3) begin
      checks++; if (rb_words[0] !== 4'hF) begin fails++; $display("[TB] FAIL rb_word0: got %h expected F", rb_words[0]); end
      checks++; if (rb_words[1] !== 4'hF) begin fails++; $display("[TB] FAIL rb_word1: got %h expected F", rb_words[1]); end
      checks++; if (rb_words[2] !== 4'h3) begin fails++; $display("[TB] FAIL rb_word2: got %h expected 3", rb_words[2]); end
    end
    checks++; if (chain !== 10'b0) begin fails++; $display("[TB] FAIL rb_chain_cleared: got %b expected 0", chain); end
  endtask
`else
  task automatic test_no_readback;
    checks++; if (rb_total != 0) begin fails++; $display("[TB] FAIL no_rb_valid_seen: got %0d expected 0", rb_total); end
    checks++; if (rb_data !== 4'h0) begin fails++; $display("[TB] FAIL no_rb_data: got %h expected 0", rb_data); end
  endtask
`endif

  // Bounded run time in case a scenario wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    s_if.s_data  = '0;
    s_if.s_valid = 1'b0;
    test_reset();
    test_basic_load();
    test_stall();
    test_start_while_busy();
    test_reset_mid_shift();
`ifdef CCFF_READBACK_EN
    test_readback();
`else
    test_no_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
